// File: rtl/vec100_deser_if.sv
// Handshake bundle for vec100_deser: serial input side, word output slot and fill count.
interface vec100_deser_if #(
    parameter int W = 100
);
    logic         in_bit;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out;
    logic         out_valid;
    logic         out_ready;
    logic [6:0]   count;

    modport master (
        output in_bit,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out,
        input  out_valid,
        input  count
    );

    modport slave (
        input  in_bit,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out,
        output out_valid,
        output count
    );
endinterface

// File: rtl/vec100_deser.sv
// vec100_deser: serial-to-parallel front end assembling W bits into a registered word slot.
// Build macro VEC100_DESER_MSB_FIRST_EN selects MSB-first ordering (default LSB-first).
module vec100_deser #(
    parameter int W = 100
) (
    input  logic          clk,
    input  logic          reset,
    vec100_deser_if.slave bus
);
    localparam logic [6:0] LAST_CNT = 7'(W - 1);

    typedef enum logic [1:0] {
        FILL_EMPTY   = 2'd0,
        FILL_FILLING = 2'd1,
        FILL_LAST    = 2'd2
    } fill_state_e;

    logic [W-1:0] sh_q, sh_d;
    logic [6:0]   count_q, count_d;
    logic [W-1:0] out_q, out_d;
    logic         out_valid_q, out_valid_d;

    fill_state_e  fill_state_s;
    logic [W-1:0] sh_shift_s;
    logic         in_ready_s;
    logic         in_xfer_s;
    logic         out_xfer_s;
    logic         complete_s;

    // Only the final bit of a word can stall: the slot must be free or draining.
    assign in_ready_s = !((count_q == LAST_CNT) && out_valid_q && !bus.out_ready);
    assign in_xfer_s  = bus.in_valid && in_ready_s;
    assign out_xfer_s = out_valid_q && bus.out_ready;

`ifdef VEC100_DESER_MSB_FIRST_EN
    assign sh_shift_s = {sh_q[W-2:0], bus.in_bit};
`else
    assign sh_shift_s = {bus.in_bit, sh_q[W-1:1]};
`endif

    // Decode the fill state from the bit counter.
    always_comb begin
        fill_state_s = FILL_FILLING;
        if (count_q == 7'd0) begin
            fill_state_s = FILL_EMPTY;
        end else if (count_q == LAST_CNT) begin
            fill_state_s = FILL_LAST;
        end else begin
            fill_state_s = FILL_FILLING;
        end
    end

    assign complete_s = in_xfer_s && (fill_state_s == FILL_LAST);

    // Next-state for the fill side and the output slot.
    always_comb begin
        sh_d        = sh_q;
        count_d     = count_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        if (in_xfer_s) begin
            sh_d = sh_shift_s;
            case (fill_state_s)
                FILL_EMPTY:   count_d = count_q + 7'd1;
                FILL_FILLING: count_d = count_q + 7'd1;
                FILL_LAST:    count_d = 7'd0;
                default:      count_d = 7'd0;
            endcase
        end else begin
            sh_d    = sh_q;
            count_d = count_q;
        end

        // A completion wins over a drain; a simultaneous drain just hands over the slot.
        if (complete_s) begin
            out_d       = sh_shift_s;
            out_valid_d = 1'b1;
        end else if (out_xfer_s) begin
            out_d       = out_q;
            out_valid_d = 1'b0;
        end else begin
            out_d       = out_q;
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q        <= '0;
            count_q     <= 7'd0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            sh_q        <= sh_d;
            count_q     <= count_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.count     = count_q;
endmodule

// File: doc/vec100_deser.md
# vec100_deser

Serial-to-parallel front end for the 100-bit vector path. Accepts one bit per cycle over a valid/ready handshake, assembles 100 bits into a word, and presents the finished word on a registered 100-bit output with its own valid/ready handshake. It sits directly upstream of the 100-bit bit-reversal stage and feeds that stage's `in` bus. A one-word output slot lets assembly of the next word overlap consumption of the current one.

## Interface
- `W`, 100, word width in bits; legal range 2..128; counter width is 7 bits for W ≤ 128.
- `clk`  input  1  rising-edge clock, sole clock domain.
- `reset`  input  1  synchronous, active-high reset, sampled on `clk` rising edge.
- `in_bit`  input  1  serial data bit.
- `in_valid`  input  1  `in_bit` is valid this cycle.
- `in_ready`  output  1  block can accept `in_bit` this cycle (combinational).
- `out`  output  W  assembled word, registered.
- `out_valid`  output  1  `out` holds an unconsumed word.
- `out_ready`  input  1  downstream consumes `out` this cycle.
- `count`  output  7  bits accepted into the current partial word, 0..W-1.

## Operation
- Input transfer when `in_valid && in_ready`; output transfer when `out_valid && out_ready`.
- Shift register `sh[W-1:0]` and counter `count` form the fill side; `out` and `out_valid` form the output slot.
- Fill states, encoded by `count`:
  - EMPTY: `count`==0.
  - FILLING: 0<`count`<W-1.
  - LAST: `count`==W-1.
- On each input transfer, `in_bit` is shifted into `sh` and `count` increments.
- On an input transfer in LAST, the completed word is written to `out`, `out_valid` is set, `count` wraps to 0, and the fill side returns to EMPTY.
- `in_ready` = !(`count`==W-1 && `out_valid` && !`out_ready`). Only the final bit of a word stalls, and only while the slot is occupied and not being drained. Bits 0..W-2 are always accepted.
- Output slot:
  - An output transfer with no simultaneous completion clears `out_valid`. `out` keeps its stale value.
  - An output transfer in the same cycle as a completion reloads `out` with the new word, and `out_valid` stays 1.
- Bit ordering (default, LSB-first): the first accepted bit of a word lands in `out[0]` and the last in `out[W-1]`. This is achieved by shifting right: `sh <= {in_bit, sh[W-1:1]}`.
- `in_bit` is ignored when no input transfer occurs. `sh` and `count` hold.
- `reset` in mid-word discards the partial word. `reset` with `out_valid`=1 discards the pending word. There is no flush of partial words.

## Timing
- Reset values: `out`=0, `out_valid`=0, `count`=0, `sh`=0. `in_ready`=1 in the cycle following reset release.
- Latency: `out_valid` rises on the clock edge that accepts bit W-1, so it is visible in the next cycle.
- Throughput: one word per W cycles sustained, with no bubble at word boundaries when `out_ready` is held high.
- `in_ready` depends combinationally on `out_ready`. The downstream stage must not derive `out_ready` from `in_ready`.
- `out` is stable whenever `out_valid`=1 and `out_ready`=0.

## Configuration
- `VEC100_DESER_MSB_FIRST_EN` defined:
  - The first accepted bit lands in `out[W-1]` and the last in `out[0]`.
  - Shift is left: `sh <= {sh[W-2:0], in_bit}`.
  - All handshake and timing behaviour is unchanged.
- Undefined: LSB-first, as described under Operation.

## Test plan
- Reset then stream: assert `reset` 2 cycles, check all outputs are 0. Feed 100 bits with `in_valid`=1 and `out_ready`=0, pattern bit k = k[0] (alternating 0,1,...). Expect `out` = 100'hAAAA…AAAA (LSB-first) with `out_valid`=1 one cycle after bit 99 is accepted. Expect `count`=0 after the wrap.
- Backpressure: hold `out_ready`=0 with `out_valid`=1 and feed 99 more bits. Expect `in_ready`=1 through `count`=98, then `in_ready`=0 at `count`=99 with `out` unchanged. Raise `out_ready` for 1 cycle: expect bit 99 accepted, `out` reloaded, and `out_valid` still 1.
- Back-to-back: hold `in_valid`=1 and `out_ready`=1 for 300 cycles with $random data. Expect exactly 3 `out_valid` words, each matching the reference model, and 0 stall cycles.
- Gapped input: toggle `in_valid` every cycle over 200 cycles. Expect one word after 200 cycles, with `count` advancing only on valid cycles.
- Mid-word reset: accept 37 bits, then assert `reset` for 1 cycle. Expect `count`=0 and `out_valid`=0. The next 100 bits must form a clean word with no residue.
- MSB-first build: with `VEC100_DESER_MSB_FIRST_EN` defined, feed 1 followed by 99 zeros. Expect `out` = 1 << 99. With the macro undefined, expect `out` = 1.
